mdr_mem_port: RTL

//   Parametrised Memory Data Register with its own memory handshake. Loads from

---
 rtl/mdr_mem_port.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mdr_mem_port.sv
// Memory Data Register with a req/ack memory port: bus loads, lane-selected
// reads with sign/zero extension, lane-aligned writes and a wait-state timeout.
module mdr_mem_port #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int OFF_W  = $clog2(DATA_W / 8),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [OFF_W-1:0]  ByteOff,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] Q,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              align_err
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ERR} state_t;

    state_t            state;
    state_t            state_n;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [OFF_W-1:0]  off_q;
    logic [CNT_W-1:0]  cnt;
    logic              start;
    logic              legal;
    logic              expire;
    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] q_lane;
    logic [DATA_W-1:0] wdata_n;
    logic [BE_W-1:0]   be_n;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_ext;

    // NOTE: every flop uses non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        // NOTE: default first so that no path leaves state_n unassigned and infers a latch.
        state_n = state;
        case (state)
            IDLE:             if (start) state_n = !legal ? ERR : (Read ? RD_WAIT : WR_WAIT);
            RD_WAIT, WR_WAIT: if (mem_ack || expire) state_n = IDLE;
            ERR:              state_n = IDLE;
            default:          state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Request decode: alignment, write lanes, and read-lane extraction with extension.
    always_comb begin
        start  = (state == IDLE) && (Read || Write);
        expire = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
        case (Size)
            2'b00: begin
                legal = 1'b1;                   lane_mask = 4'b0001; q_lane = DATA_W'(Q[7:0]);
            end
            2'b01: begin
                legal = !ByteOff[0];            lane_mask = 4'b0011; q_lane = DATA_W'(Q[15:0]);
            end
            2'b10: begin
                legal = (ByteOff[1:0] == 2'b00); lane_mask = 4'b1111; q_lane = DATA_W'(Q[31:0]);
            end
            default: begin
                legal = 1'b0;                   lane_mask = 4'b0000; q_lane = '0;
            end
        endcase
        wdata_n  = q_lane << {ByteOff, 3'b000};
        be_n     = BE_W'(lane_mask) << ByteOff;
        rd_shift = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   rd_ext = unsigned_q ? DATA_W'(rd_shift[7:0])  : DATA_W'($signed(rd_shift[7:0]));
            2'b01:   rd_ext = unsigned_q ? DATA_W'(rd_shift[15:0]) : DATA_W'($signed(rd_shift[15:0]));
            default: rd_ext = unsigned_q ? DATA_W'(rd_shift[31:0]) : DATA_W'($signed(rd_shift[31:0]));
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Q           <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            align_err   <= 1'b0;
            cnt         <= '0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            off_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        size_q      <= Size;
                        unsigned_q  <= Unsigned;
                        off_q       <= ByteOff;
                        cnt         <= '0;
                        timeout_err <= 1'b0;
                        align_err   <= !legal;
                        if (legal) begin
                            mem_req <= 1'b1;
                            mem_we  <= !Read;
                            if (!Read) begin
                                mem_wdata <= wdata_n;
                                mem_be    <= be_n;
                            end
                        end
                    end else if (MDRin) begin
                        Q <= BusMuxOut;
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (mem_ack || expire) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        done    <= 1'b1;
                        // Ack on the last permitted edge still completes normally.
                        if (mem_ack && state == RD_WAIT) Q <= rd_ext;
                        if (!mem_ack) timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR:     done <= 1'b1;
                default: done <= 1'b0;
            endcase
        end
    end

endmodule
